// File: rtl/offnariscv_pkg.sv
// Shared ACE encodings and widths for the read responder and its address generator.
package offnariscv_pkg;

  localparam int unsigned ACE_XID_WIDTH     = 4;
  localparam int unsigned ACE_AXLEN_WIDTH   = 8;
  localparam int unsigned ACE_AXSIZE_WIDTH  = 3;
  localparam int unsigned ACE_AXBURST_WIDTH = 2;
  localparam int unsigned ACE_ARSNOOP_WIDTH = 4;
  localparam int unsigned ACE_DOMAIN_WIDTH  = 2;
  localparam int unsigned ACE_RRESP_WIDTH   = 4;

  typedef enum logic [ACE_AXBURST_WIDTH-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } ace_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READ_NO_SNOOP = 4'b0000;
  localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READ_SHARED   = 4'b0001;
  localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READ_CLEAN    = 4'b0010;
  localparam logic [ACE_ARSNOOP_WIDTH-1:0] ARSNOOP_READ_UNIQUE   = 4'b0111;

  localparam logic [ACE_DOMAIN_WIDTH-1:0] DOMAIN_NON_SHAREABLE = 2'b00;
  localparam logic [ACE_DOMAIN_WIDTH-1:0] DOMAIN_INNER         = 2'b01;
  localparam logic [ACE_DOMAIN_WIDTH-1:0] DOMAIN_OUTER         = 2'b10;
  localparam logic [ACE_DOMAIN_WIDTH-1:0] DOMAIN_SYSTEM        = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BEAT,
    ST_WAIT_RACK
  } rd_state_e;

  // AR fields held for the lifetime of one burst
  typedef struct packed {
    logic [ACE_XID_WIDTH-1:0]     id;
    logic [ACE_AXLEN_WIDTH-1:0]   len;
    logic [ACE_AXSIZE_WIDTH-1:0]  size;
    logic [ACE_AXBURST_WIDTH-1:0] burst;
    logic                         shared;
  } ar_meta_t;

  function automatic logic is_shared(input logic [ACE_ARSNOOP_WIDTH-1:0] snoop,
                                     input logic [ACE_DOMAIN_WIDTH-1:0]  domain);
    return (snoop == ARSNOOP_READ_SHARED) &&
           ((domain == DOMAIN_INNER) || (domain == DOMAIN_OUTER));
  endfunction

endpackage

// File: rtl/ace_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus WRAP legality check.
module ace_burst_addr_gen
  import offnariscv_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]                addr_i,
  input  logic [ACE_AXLEN_WIDTH-1:0]   len_i,
  input  logic [ACE_AXSIZE_WIDTH-1:0]  size_i,
  input  logic [ACE_AXBURST_WIDTH-1:0] burst_i,
  output logic [AW-1:0]                next_addr_o,
  output logic                         wrap_err_o
);

  logic [AW-1:0] bytes;
  logic [AW-1:0] aligned;
  logic [AW-1:0] incr;
  logic [AW-1:0] boundary;
  logic [AW-1:0] base;
  logic          len_ok;

  always_comb begin
    bytes    = AW'(1) << size_i;
    aligned  = addr_i & ~(bytes - AW'(1));
    incr     = aligned + bytes;
    boundary = bytes * (AW'(len_i) + AW'(1));
    base     = addr_i & ~(boundary - AW'(1));
    len_ok   = (len_i == ACE_AXLEN_WIDTH'(1)) || (len_i == ACE_AXLEN_WIDTH'(3)) ||
               (len_i == ACE_AXLEN_WIDTH'(7)) || (len_i == ACE_AXLEN_WIDTH'(15));
    wrap_err_o = (burst_i == BURST_WRAP) && (!len_ok || (addr_i != aligned));

    // Illegal WRAP and the reserved encoding fall back to INCR
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (!wrap_err_o && (incr == base + boundary)) ? base : incr;
      default:     next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/ace_rd_responder.sv
// Slave-side ACE read responder: one outstanding AR, R bursts from a line-wide array, RACK tracking.
// Define ACE_RD_RANDOM_STALL_EN to insert LFSR-driven bubbles on AR acceptance and array fetch.
module ace_rd_responder
  import offnariscv_pkg::*;
#(
  parameter int unsigned ACE_XDATA_WIDTH  = 256,
  parameter int unsigned ACE_AXADDR_WIDTH = 32,
  parameter int unsigned MEM_DEPTH        = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ACE_XID_WIDTH-1:0]      ar_id,
  input  logic [ACE_AXADDR_WIDTH-1:0]   ar_addr,
  input  logic [ACE_AXLEN_WIDTH-1:0]    ar_len,
  input  logic [ACE_AXSIZE_WIDTH-1:0]   ar_size,
  input  logic [ACE_AXBURST_WIDTH-1:0]  ar_burst,
  input  logic [ACE_ARSNOOP_WIDTH-1:0]  ar_snoop,
  input  logic [ACE_DOMAIN_WIDTH-1:0]   ar_domain,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [ACE_XID_WIDTH-1:0]      r_id,
  output logic [ACE_XDATA_WIDTH-1:0]    r_data,
  output logic [ACE_RRESP_WIDTH-1:0]    r_resp,
  output logic                          r_last,
  output logic                          r_valid,
  input  logic                          r_ready,
  input  logic                          rack,
  input  logic                          mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]  mem_waddr,
  input  logic [ACE_XDATA_WIDTH-1:0]    mem_wdata,
  output logic                          proto_err
);

  localparam int unsigned AW     = ACE_AXADDR_WIDTH;
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned OFFS_W = $clog2(ACE_XDATA_WIDTH / 8);

  rd_state_e                        state_q, state_d;
  ar_meta_t                         meta_q, meta_d;
  logic [AW-1:0]                    addr_q, addr_d;
  logic [ACE_AXLEN_WIDTH-1:0]       cnt_q, cnt_d;
  logic                             ar_ready_q, ar_ready_d;
  logic                             r_valid_q, r_valid_d;
  logic                             r_last_q, r_last_d;
  logic [ACE_XID_WIDTH-1:0]         r_id_q, r_id_d;
  logic [ACE_XDATA_WIDTH-1:0]       r_data_q, r_data_d;
  logic [ACE_RRESP_WIDTH-1:0]       r_resp_q, r_resp_d;
  logic                             proto_err_q, proto_err_d;

  logic [ACE_XDATA_WIDTH-1:0]       mem [MEM_DEPTH];
  logic [AW-1:0]                    word_idx;
  logic                             in_range;

  logic [AW-1:0]                    gen_addr, next_addr;
  logic [ACE_AXLEN_WIDTH-1:0]       gen_len;
  logic [ACE_AXSIZE_WIDTH-1:0]      gen_size;
  logic [ACE_AXBURST_WIDTH-1:0]     gen_burst;
  logic                             wrap_err;
  logic                             stall_fetch, stall_ar;

`ifdef ACE_RD_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  // ar_ready is registered, so judge it by the LFSR value live in the cycle it is shown
  assign stall_fetch = (lfsr_q[1:0] == 2'b00);
  assign stall_ar    = (lfsr_d[3:2] == 2'b00);
`else
  assign stall_fetch = 1'b0;
  assign stall_ar    = 1'b0;
`endif

  // Backdoor preload; no reset so the array maps onto a plain RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // In IDLE the generator checks the incoming AR; afterwards it walks the captured burst
  always_comb begin
    gen_addr  = addr_q;
    gen_len   = meta_q.len;
    gen_size  = meta_q.size;
    gen_burst = meta_q.burst;
    if (state_q == ST_IDLE) begin
      gen_addr  = ar_addr;
      gen_len   = ar_len;
      gen_size  = ar_size;
      gen_burst = ar_burst;
    end
  end

  ace_burst_addr_gen #(.AW(AW)) u_addr_gen (
    .addr_i      (gen_addr),
    .len_i       (gen_len),
    .size_i      (gen_size),
    .burst_i     (gen_burst),
    .next_addr_o (next_addr),
    .wrap_err_o  (wrap_err)
  );

  assign word_idx = addr_q >> OFFS_W;
  assign in_range = (word_idx < AW'(MEM_DEPTH));

  always_comb begin
    state_d     = state_q;
    meta_d      = meta_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ar_ready_d  = 1'b0;
    r_valid_d   = r_valid_q;
    r_last_d    = r_last_q;
    r_id_d      = r_id_q;
    r_data_d    = r_data_q;
    r_resp_d    = r_resp_q;
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (ar_valid && ar_ready_q) begin
          meta_d = '{id:     ar_id,
                     len:    ar_len,
                     size:   ar_size,
                     burst:  wrap_err ? ACE_AXBURST_WIDTH'(BURST_INCR) : ar_burst,
                     shared: is_shared(ar_snoop, ar_domain)};
          addr_d  = ar_addr;
          cnt_d   = ar_len;
          state_d = ST_FETCH;
          if (wrap_err) proto_err_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (!stall_fetch) begin
          r_valid_d = 1'b1;
          r_id_d    = meta_q.id;
          r_last_d  = (cnt_q == '0);
          if (in_range) begin
            r_data_d = mem[word_idx[IDX_W-1:0]];
            r_resp_d = {meta_q.shared, 1'b0, RESP_OKAY};
          end else begin
            r_data_d = '0;
            r_resp_d = {meta_q.shared, 1'b0, RESP_DECERR};
          end
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - ACE_AXLEN_WIDTH'(1);
            addr_d  = next_addr;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WAIT_RACK;
          end
        end
      end
      ST_WAIT_RACK: begin
        if (rack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (rack && (state_q != ST_WAIT_RACK)) proto_err_d = 1'b1;
    ar_ready_d = (state_d == ST_IDLE) && !stall_ar;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      meta_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      ar_ready_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      r_last_q    <= 1'b0;
      r_id_q      <= '0;
      r_data_q    <= '0;
      r_resp_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      meta_q      <= meta_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ar_ready_q  <= ar_ready_d;
      r_valid_q   <= r_valid_d;
      r_last_q    <= r_last_d;
      r_id_q      <= r_id_d;
      r_data_q    <= r_data_d;
      r_resp_q    <= r_resp_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign ar_ready  = ar_ready_q;
  assign r_valid   = r_valid_q;
  assign r_last    = r_last_q;
  assign r_id      = r_id_q;
  assign r_data    = r_data_q;
  assign r_resp    = r_resp_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ace_rd_responder.sv
// Directed bench for ace_rd_responder: latency, INCR/WRAP ordering, backpressure, DECERR, IsShared, RACK and reset.
module tb_ace_rd_responder;
  import offnariscv_pkg::*;

  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IW    = $clog2(DEPTH);

  logic                         clk = 1'b0;
  logic                         rst;
  logic [ACE_XID_WIDTH-1:0]     ar_id;
  logic [AW-1:0]                ar_addr;
  logic [ACE_AXLEN_WIDTH-1:0]   ar_len;
  logic [ACE_AXSIZE_WIDTH-1:0]  ar_size;
  logic [ACE_AXBURST_WIDTH-1:0] ar_burst;
  logic [ACE_ARSNOOP_WIDTH-1:0] ar_snoop;
  logic [ACE_DOMAIN_WIDTH-1:0]  ar_domain;
  logic                         ar_valid;
  logic                         ar_ready;
  logic [ACE_XID_WIDTH-1:0]     r_id;
  logic [DW-1:0]                r_data;
  logic [ACE_RRESP_WIDTH-1:0]   r_resp;
  logic                         r_last;
  logic                         r_valid;
  logic                         r_ready;
  logic                         rack;
  logic                         mem_we;
  logic [IW-1:0]                mem_waddr;
  logic [DW-1:0]                mem_wdata;
  logic                         proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] got_data [16];
  logic [3:0]    got_resp [16];
  logic          got_last [16];
  int            n_beats;

  always #5 clk = ~clk;

  ace_rd_responder #(
    .ACE_XDATA_WIDTH  (DW),
    .ACE_AXADDR_WIDTH (AW),
    .MEM_DEPTH        (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ar_id     (ar_id),
    .ar_addr   (ar_addr),
    .ar_len    (ar_len),
    .ar_size   (ar_size),
    .ar_burst  (ar_burst),
    .ar_snoop  (ar_snoop),
    .ar_domain (ar_domain),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .r_id      (r_id),
    .r_data    (r_data),
    .r_resp    (r_resp),
    .r_last    (r_last),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .rack      (rack),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .proto_err (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input int val);
    mem_we    = 1'b1;
    mem_waddr = IW'(idx);
    mem_wdata = DW'(val);
    tick();
    mem_we    = 1'b0;
  endtask

  // Returns one cycle into the cycle after the AR handshake
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [3:0] snoop, input logic [1:0] domain);
    int t = 0;
    while (ar_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (ar_ready !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ar_ready_timeout got %b want 1", ar_ready);
    end
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size;
    ar_burst = burst; ar_snoop = snoop; ar_domain = domain;
    ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
  endtask

  // Accept beats with r_ready high until r_last is consumed
  task automatic collect();
    int  t = 0;
    logic done = 1'b0;
    n_beats = 0;
    r_ready = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk);
      if (r_valid === 1'b1 && n_beats < 16) begin
        got_data[n_beats] = r_data;
        got_resp[n_beats] = r_resp;
        got_last[n_beats] = r_last;
        n_beats++;
        if (r_last === 1'b1) done = 1'b1;
      end
      t++;
    end
    tick();
    r_ready = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL collect_timeout got %0d beats want r_last", n_beats);
    end
  endtask

  task automatic do_rack();
    rack = 1'b1;
    tick();
    rack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ar_valid = 1'b0; r_ready = 1'b0; rack = 1'b0; mem_we = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    ar_snoop = '0; ar_domain = '0; mem_waddr = '0; mem_wdata = '0;
    repeat (2) tick();
    n_cmp++;
    if ({ar_ready, r_valid, r_last, proto_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0000", {ar_ready, r_valid, r_last, proto_err});
    end
    n_cmp++;
    if ({r_id, r_resp} !== 8'h00 || r_data !== '0) begin
      n_fail++;
      $display("FAIL reset_payload got id=%0h resp=%0h data=%0h want 0", r_id, r_resp, r_data);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ar_ready got %b want 1", ar_ready);
    end
  endtask

  task automatic test_incr();
    for (int i = 0; i < 8; i++) preload(i, i + 1);
    r_ready = 1'b1;
    send_ar(4'h1, 32'h0, 8'd1, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    n_cmp++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_fetch_cycle got r_valid=%b ar_ready=%b want 0 0", r_valid, ar_ready);
    end
    tick();
    n_cmp++;
    if ({r_valid, r_last, r_id} !== {1'b1, 1'b0, 4'h1} || r_data !== DW'(1)) begin
      n_fail++;
      $display("FAIL incr_beat0 got v=%b l=%b id=%0h d=%0h want 1 0 1 1", r_valid, r_last, r_id, r_data);
    end
    tick();
    n_cmp++;
    if (r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_gap got r_valid=%b want 0", r_valid);
    end
    tick();
    n_cmp++;
    if ({r_valid, r_last, r_resp} !== {1'b1, 1'b1, 4'h0} || r_data !== DW'(2)) begin
      n_fail++;
      $display("FAIL incr_beat1 got v=%b l=%b resp=%0h d=%0h want 1 1 0 2", r_valid, r_last, r_resp, r_data);
    end
    tick();
    r_ready = 1'b0;
    n_cmp++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_wait_rack got r_valid=%b ar_ready=%b want 0 0", r_valid, ar_ready);
    end
    do_rack();
    n_cmp++;
    if (ar_ready !== 1'b1 || proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL incr_after_rack got ar_ready=%b proto_err=%b want 1 0", ar_ready, proto_err);
    end
  endtask

  task automatic test_wrap();
    int exp_d [4] = '{3, 4, 1, 2};
    send_ar(4'h2, 32'h40, 8'd3, 3'd5, BURST_WRAP, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    collect();
    n_cmp++;
    if (n_beats != 4) begin
      n_fail++;
      $display("FAIL wrap_beat_count got %0d want 4", n_beats);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_d[i]) || got_resp[i] !== 4'h0 || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d got d=%0h resp=%0h last=%b want d=%0h resp=0 last=%b",
                 i, got_data[i], got_resp[i], got_last[i], exp_d[i], (i == 3));
      end
    end
    do_rack();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_proto_err got %b want 0", proto_err);
    end
  endtask

  task automatic test_backpressure();
    int t = 0;
    r_ready = 1'b0;
    send_ar(4'h5, 32'h0, 8'd3, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    while (r_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({r_valid, r_id, r_last} !== {1'b1, 4'h5, 1'b0} || r_data !== DW'(1)) begin
        n_fail++;
        $display("FAIL stall_hold%0d got v=%b id=%0h l=%b d=%0h want 1 5 0 1", i, r_valid, r_id, r_last, r_data);
      end
    end
    r_ready = 1'b1;
    tick();
    collect();
    n_cmp++;
    if (n_beats != 3 || got_data[0] !== DW'(2) || got_data[1] !== DW'(3) || got_data[2] !== DW'(4)
        || got_last[1] !== 1'b0 || got_last[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_rest got n=%0d d=%0h,%0h,%0h want 3 beats 2,3,4", n_beats,
               got_data[0], got_data[1], got_data[2]);
    end
    do_rack();
  endtask

  task automatic test_decerr();
    send_ar(4'h3, 32'h8000, 8'd0, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    collect();
    n_cmp++;
    if (n_beats != 1 || got_resp[0][1:0] !== RESP_DECERR || got_data[0] !== '0 || got_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL decerr got n=%0d resp=%0h d=%0h l=%b want 1 3 0 1", n_beats, got_resp[0], got_data[0], got_last[0]);
    end
    do_rack();
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL decerr_proto_err got %b want 0", proto_err);
    end
  endtask

  task automatic test_shared();
    send_ar(4'h6, 32'h20, 8'd0, 3'd5, BURST_INCR, ARSNOOP_READ_SHARED, DOMAIN_INNER);
    collect();
    n_cmp++;
    if (got_resp[0] !== 4'b1000 || got_data[0] !== DW'(2)) begin
      n_fail++;
      $display("FAIL shared_inner got resp=%0h d=%0h want 8 2", got_resp[0], got_data[0]);
    end
    do_rack();
    send_ar(4'h6, 32'h20, 8'd0, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    collect();
    n_cmp++;
    if (got_resp[0] !== 4'b0000) begin
      n_fail++;
      $display("FAIL shared_nosnoop got resp=%0h want 0", got_resp[0]);
    end
    do_rack();
  endtask

  task automatic test_proto_err();
    do_rack();
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL rack_idle got %b want 1", proto_err);
    end
    repeat (3) tick();
    n_cmp++;
    if (proto_err !== 1'b1 || ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rack_sticky got proto_err=%b ar_ready=%b want 1 1", proto_err, ar_ready);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    r_ready = 1'b0;
    send_ar(4'h7, 32'h0, 8'd3, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    while (r_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({r_valid, ar_ready, proto_err, r_last} !== 4'b0000 || r_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got v=%b rdy=%b perr=%b l=%b d=%0h want 0", r_valid, ar_ready, proto_err, r_last, r_data);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle got ar_ready=%b r_valid=%b want 1 0", ar_ready, r_valid);
    end
    send_ar(4'h8, 32'h60, 8'd0, 3'd5, BURST_INCR, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    collect();
    n_cmp++;
    if (n_beats != 1 || got_data[0] !== DW'(4)) begin
      n_fail++;
      $display("FAIL reset_mid_fresh got n=%0d d=%0h want 1 4", n_beats, got_data[0]);
    end
    do_rack();
  endtask

  task automatic test_wrap_illegal();
    send_ar(4'h9, 32'h20, 8'd2, 3'd5, BURST_WRAP, ARSNOOP_READ_NO_SNOOP, DOMAIN_NON_SHAREABLE);
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_illegal_flag got %b want 1", proto_err);
    end
    collect();
    n_cmp++;
    if (n_beats != 3 || got_data[0] !== DW'(2) || got_data[1] !== DW'(3) || got_data[2] !== DW'(4)) begin
      n_fail++;
      $display("FAIL wrap_illegal_incr got n=%0d d=%0h,%0h,%0h want 3 beats 2,3,4", n_beats,
               got_data[0], got_data[1], got_data[2]);
    end
    do_rack();
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_decerr();
    test_shared();
    test_proto_err();
    test_reset_mid();
    test_wrap_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
